// File: rtl/inst_rom_loader.sv
// Instruction ROM filled by a big-endian byte-stream loader; holds the CPU in reset until loaded.
// Optional byte checksum enabled by defining INST_ROM_LOADER_CHECKSUM_EN.
module inst_rom_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_valid_i,
  input  logic [7:0]            ld_data_i,
  input  logic                  ld_last_i,
  output logic                  ld_ready_o,
  input  logic                  rom_ce_i,
  input  logic [31:0]           rom_addr_i,
  output logic [31:0]           rom_data_o,
  output logic                  cpu_rst_o,
  output logic                  load_done_o,
  output logic                  overflow_o,
  output logic [ADDR_WIDTH:0]   word_count_o,
  output logic [7:0]            checksum_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [31:0]         wbuf_q, wbuf_d;
  logic [ADDR_WIDTH:0] word_cnt_q, word_cnt_d;
  logic                ovf_q, ovf_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic                cpu_rst_q, cpu_rst_d;

  logic [31:0]         mem [DEPTH];
  logic                accept;
  logic                wr_req;
  logic                wr_en;
  logic [31:0]         wr_word;
  logic [31:0]         wbuf_fill;
  logic                unused_addr;

  assign accept = ld_valid_i && ready_q;

  always_comb begin
    wbuf_fill = wbuf_q;
    case (byte_idx_q)
      2'd0: wbuf_fill[31:24] = ld_data_i;
      2'd1: wbuf_fill[23:16] = ld_data_i;
      2'd2: wbuf_fill[15:8]  = ld_data_i;
      default: wbuf_fill[7:0] = ld_data_i;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    wbuf_d     = wbuf_q;
    wr_req     = 1'b0;
    wr_word    = wbuf_q;
    case (state_q)
      S_IDLE, S_LOAD: begin
        if (accept) begin
          state_d    = ld_last_i ? S_FLUSH : S_LOAD;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            wr_req  = 1'b1;
            wr_word = wbuf_fill;
            wbuf_d  = '0;
          end else begin
            wbuf_d = wbuf_fill;
          end
        end
      end
      S_FLUSH: begin
        // Unfilled low lanes are already zero, so the buffer is the padded word.
        if (byte_idx_q != 2'd0) begin
          wr_req = 1'b1;
        end
        byte_idx_d = 2'd0;
        wbuf_d     = '0;
        state_d    = S_DONE;
      end
      default: ;
    endcase
  end

  always_comb begin
    wr_en      = wr_req && (word_cnt_q != FULL_CNT);
    word_cnt_d = wr_en ? word_cnt_q + CNT_ONE : word_cnt_q;
    ovf_d      = ovf_q | (wr_req && !wr_en);
    ready_d    = (state_d == S_IDLE) || (state_d == S_LOAD);
    done_d     = (state_d == S_DONE);
    cpu_rst_d  = (state_q != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      byte_idx_q <= 2'd0;
      wbuf_q     <= '0;
      word_cnt_q <= '0;
      ovf_q      <= 1'b0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      cpu_rst_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      wbuf_q     <= wbuf_d;
      word_cnt_q <= word_cnt_d;
      ovf_q      <= ovf_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      cpu_rst_q  <= cpu_rst_d;
    end
  end

  // Memory contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[word_cnt_q[ADDR_WIDTH-1:0]] <= wr_word;
    end
  end

  assign rom_data_o  = rom_ce_i ? mem[rom_addr_i[ADDR_WIDTH+1:2]] : 32'h0;
  assign unused_addr = ^{rom_addr_i[31:ADDR_WIDTH+2], rom_addr_i[1:0]};

  assign ld_ready_o   = ready_q;
  assign cpu_rst_o    = cpu_rst_q;
  assign load_done_o  = done_q;
  assign overflow_o   = ovf_q;
  assign word_count_o = word_cnt_q;

`ifdef INST_ROM_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  always_comb begin
    csum_d = accept ? csum_q + ld_data_i : csum_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= 8'h00;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum_o = csum_q;
`else
  assign checksum_o = 8'h00;
`endif

endmodule

// File: tb/tb_inst_rom_loader.sv
// Bench for inst_rom_loader: a 1024-word and a 4-word instance share one loader stream
// and are checked against an image-level model.
module tb_inst_rom_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_last;
  logic        rom_ce;
  logic [31:0] rom_addr;

  logic        ready_b, cpu_rst_b, done_b, ovf_b;
  logic [31:0] rom_data_b;
  logic [10:0] wc_b;
  logic [7:0]  cs_b;
  logic        ready_s, cpu_rst_s, done_s, ovf_s;
  logic [31:0] rom_data_s;
  logic [2:0]  wc_s;
  logic [7:0]  cs_s;

  always #5 clk = ~clk;

  inst_rom_loader #(.ADDR_WIDTH(10)) u_big (
    .clk(clk), .rst(rst), .ld_valid_i(ld_valid), .ld_data_i(ld_data), .ld_last_i(ld_last),
    .ld_ready_o(ready_b), .rom_ce_i(rom_ce), .rom_addr_i(rom_addr), .rom_data_o(rom_data_b),
    .cpu_rst_o(cpu_rst_b), .load_done_o(done_b), .overflow_o(ovf_b),
    .word_count_o(wc_b), .checksum_o(cs_b)
  );

  inst_rom_loader #(.ADDR_WIDTH(2)) u_small (
    .clk(clk), .rst(rst), .ld_valid_i(ld_valid), .ld_data_i(ld_data), .ld_last_i(ld_last),
    .ld_ready_o(ready_s), .rom_ce_i(rom_ce), .rom_addr_i(rom_addr), .rom_data_o(rom_data_s),
    .cpu_rst_o(cpu_rst_s), .load_done_o(done_s), .overflow_o(ovf_s),
    .word_count_o(wc_s), .checksum_o(cs_s)
  );

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic        ce;
    logic [31:0] addr;
    logic [31:0] exp;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem_b [1024];
  bit          known_b [1024];
  logic [31:0] mem_s [4];
  bit          known_s [4];
  int          exp_wc_b, exp_wc_s;
  bit          exp_ovf_b, exp_ovf_s;
  logic [7:0]  exp_cs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input bq_t q, input int w);
    logic [31:0] r = 32'h0;
    for (int k = 0; k < 4; k++) begin
      r = {r[23:0], (w * 4 + k < q.size()) ? q[w * 4 + k] : 8'h00};
    end
    return r;
  endfunction

  // Image-level model: complete loads round up to whole words, aborted loads keep full words only.
  task automatic model_commit(input bq_t q, input bit complete);
    int nw;
    logic [7:0] sum = 8'h00;
    nw = complete ? (q.size() + 3) / 4 : q.size() / 4;
    for (int w = 0; w < nw; w++) begin
      if (w < 1024) begin mem_b[w] = word_of(q, w); known_b[w] = 1'b1; end
      if (w < 4)    begin mem_s[w] = word_of(q, w); known_s[w] = 1'b1; end
    end
    foreach (q[i]) sum = sum + q[i];
    exp_wc_b  = (nw < 1024) ? nw : 1024;
    exp_wc_s  = (nw < 4) ? nw : 4;
    exp_ovf_b = (nw > 1024);
    exp_ovf_s = (nw > 4);
`ifdef INST_ROM_LOADER_CHECKSUM_EN
    exp_cs = sum;
`else
    exp_cs = 8'h00;
`endif
  endtask

  task automatic fetch_check(input logic [31:0] addr);
    rom_ce   = 1'b1;
    rom_addr = addr;
    #1;
    if (known_b[addr[11:2]]) chk("fetch_big", rom_data_b, mem_b[addr[11:2]]);
    if (known_s[addr[3:2]])  chk("fetch_small", rom_data_s, mem_s[addr[3:2]]);
  endtask

  // Starts and ends at a negedge; random idle gaps with junk data between bytes.
  task automatic send_bytes(input bq_t q, input bit with_last, input int max_gap);
    int budget;
    foreach (q[i]) begin
      repeat ((max_gap > 0) ? $urandom_range(0, max_gap) : 0) begin
        ld_valid = 1'b0;
        ld_data  = 8'($urandom);
        ld_last  = 1'($urandom);
        @(negedge clk);
      end
      ld_valid = 1'b1;
      ld_data  = q[i];
      ld_last  = with_last && (i == q.size() - 1);
      budget   = 0;
      while (!ready_b && budget < 20) begin
        @(negedge clk);
        budget++;
      end
      if (!ready_b) chk("ready_timeout", {31'h0, ready_b}, 32'h1);
      @(negedge clk);
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // FLUSH one cycle after the last byte, DONE next, then cpu reset releases one cycle later.
  task automatic finish_seq();
    chk("flush_ready", {31'h0, ready_b}, 32'h0);
    chk("flush_done", {31'h0, done_b}, 32'h0);
    chk("flush_cpu_rst", {31'h0, cpu_rst_b}, 32'h1);
    @(negedge clk);
    chk("done_entry", {31'h0, done_b}, 32'h1);
    chk("done_entry_cpu_rst", {31'h0, cpu_rst_b}, 32'h1);
    @(negedge clk);
    chk("cpu_rst_release", {31'h0, cpu_rst_b}, 32'h0);
    chk("cpu_rst_release_small", {31'h0, cpu_rst_s}, 32'h0);
  endtask

  task automatic check_done(input int nw);
    logic [31:0] a;
    chk("wc_big", 32'(wc_b), 32'(exp_wc_b));
    chk("wc_small", 32'(wc_s), 32'(exp_wc_s));
    chk("ovf_big", {31'h0, ovf_b}, {31'h0, exp_ovf_b});
    chk("ovf_small", {31'h0, ovf_s}, {31'h0, exp_ovf_s});
    chk("done_small", {31'h0, done_s}, 32'h1);
    chk("cs_big", 32'(cs_b), 32'(exp_cs));
    chk("cs_small", 32'(cs_s), 32'(exp_cs));
    for (int w = 0; w < nw && w < 1024; w++) begin
      a = $urandom;
      a[11:2] = 10'(w);
      fetch_check(a);
    end
    rom_ce = 1'b0;
    #1;
    chk("ce_off", rom_data_b, 32'h0);
  endtask

  task automatic load_image(input bq_t q, input int gap);
    send_bytes(q, 1'b1, gap);
    finish_seq();
    model_commit(q, 1'b1);
    check_done((q.size() + 3) / 4);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vec_t vt[6];
    bq_t  q, r;

    vt[0] = '{ce: 1'b0, addr: 32'h0000_0000, exp: 32'h0000_0000};
    vt[1] = '{ce: 1'b1, addr: 32'h0000_0000, exp: 32'h3401_1100};
    vt[2] = '{ce: 1'b1, addr: 32'h0000_0003, exp: 32'h3401_1100};
    vt[3] = '{ce: 1'b1, addr: 32'h0000_1000, exp: 32'h3401_1100};
    vt[4] = '{ce: 1'b1, addr: 32'hFFFF_F002, exp: 32'h3401_1100};
    vt[5] = '{ce: 1'b0, addr: 32'h0000_1000, exp: 32'h0000_0000};

    rst = 1'b1; ld_valid = 1'b0; ld_data = 8'h00; ld_last = 1'b0;
    rom_ce = 1'b0; rom_addr = 32'h0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'h0, ready_b}, 32'h0);
    chk("rst_cpu_rst", {31'h0, cpu_rst_b}, 32'h1);
    chk("rst_done", {31'h0, done_b}, 32'h0);
    chk("rst_ovf", {31'h0, ovf_s}, 32'h0);
    chk("rst_wc", 32'(wc_b), 32'h0);
    chk("rst_cs", 32'(cs_b), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {31'h0, ready_b}, 32'h1);

    // Basic load, then table-driven fetches
    q = '{8'h34, 8'h01, 8'h11, 8'h00};
    load_image(q, 0);
    chk("basic_wc", 32'(wc_b), 32'h1);
    for (int i = 0; i < 6; i++) begin
      rom_ce = vt[i].ce;
      rom_addr = vt[i].addr;
      #1;
      chk($sformatf("vec%0d_big", i), rom_data_b, vt[i].exp);
      chk($sformatf("vec%0d_small", i), rom_data_s, vt[i].exp);
    end
    rom_ce = 1'b0;

    // Partial final word
    do_reset();
    q = '{8'h3C, 8'h01, 8'h00, 8'h10, 8'h34, 8'h21};
    load_image(q, 1);
    chk("partial_wc", 32'(wc_b), 32'h2);
    fetch_check(32'h4);
    chk("partial_word1", rom_data_b, 32'h3421_0000);
    rom_ce = 1'b0;

    // Gapped 12-byte stream, then bytes offered after DONE
    do_reset();
    q = {};
    repeat (12) q.push_back(8'($urandom));
    load_image(q, 3);
    for (int i = 0; i < 5; i++) begin
      ld_valid = 1'b1; ld_data = 8'($urandom); ld_last = 1'($urandom);
      chk("after_done_ready", {31'h0, ready_b}, 32'h0);
      @(negedge clk);
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    check_done(3);

    // Overflow on the small instance: 5 words
    do_reset();
    q = {};
    repeat (20) q.push_back(8'($urandom));
    load_image(q, 1);
    chk("ovf_small_set", {31'h0, ovf_s}, 32'h1);
    chk("ovf_small_wc", 32'(wc_s), 32'h4);
    chk("ovf_big_wc", 32'(wc_b), 32'h5);

    // Reset mid-load, then reload with a same-cycle write/fetch collision
    do_reset();
    q = {};
    repeat (6) q.push_back(8'($urandom));
    send_bytes(q, 1'b0, 0);
    model_commit(q, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_cpu_rst", {31'h0, cpu_rst_b}, 32'h1);
    chk("midrst_wc", 32'(wc_b), 32'h0);
    chk("midrst_ready", {31'h0, ready_b}, 32'h0);
    chk("midrst_cs", 32'(cs_b), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready_after", {31'h0, ready_b}, 32'h1);
    r = {};
    repeat (4) r.push_back(8'($urandom));
    send_bytes(r[0:2], 1'b0, 0);
    ld_valid = 1'b1; ld_data = r[3]; ld_last = 1'b1;
    chk("collide_ready", {31'h0, ready_b}, 32'h1);
    fetch_check(32'h0);
    @(posedge clk);
    #1;
    chk("collide_new", rom_data_b, word_of(r, 0));
    chk("collide_new_small", rom_data_s, word_of(r, 0));
    @(negedge clk);
    ld_valid = 1'b0; ld_last = 1'b0;
    finish_seq();
    model_commit(r, 1'b1);
    check_done(1);

    // Checksum
    do_reset();
    q = '{8'hFF, 8'h01, 8'h02, 8'h03};
    load_image(q, 0);
`ifdef INST_ROM_LOADER_CHECKSUM_EN
    chk("checksum_fixed", 32'(cs_b), 32'h05);
`else
    chk("checksum_fixed", 32'(cs_b), 32'h00);
`endif

    // Randomized images
    for (int it = 0; it < 8; it++) begin
      do_reset();
      q = {};
      repeat ($urandom_range(1, 24)) q.push_back(8'($urandom));
      load_image(q, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
